// File: rtl/match_timer_ctrl.sv
// Match clock sequencer for time-mode pong: prescaler, remaining-seconds counter,
// IDLE/RUNNING/PAUSED/EXPIRED control and minutes/tens/ones display digits.
module match_timer_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned WARN_SECS     = 10
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       start,
  input  logic       pause_toggle,
  input  logic       abort,
  input  logic [7:0] max_time,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [3:0] C,
  output logic       running,
  output logic       paused,
  output logic       game_over,
  output logic       sec_tick,
  output logic       warn
);

  localparam int unsigned PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned REM_W = 8;
  localparam int unsigned SEC_W = 6;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [REM_W-1:0] WARN_LIM = REM_W'(WARN_SECS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [REM_W-1:0]   r_remaining;
  logic [REM_W-1:0]   w_remaining_nxt;
  logic [PRE_W-1:0]   r_prescaler;
  logic [PRE_W-1:0]   w_prescaler_nxt;
  logic               r_sec_tick;
  logic               w_sec_tick_nxt;

  logic [REM_W-1:0]   w_disp;
  logic [SEC_W-1:0]   w_disp_sec;

  // State, counters and tick pulse
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_prescaler <= '0;
      r_sec_tick  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_prescaler <= w_prescaler_nxt;
      r_sec_tick  <= w_sec_tick_nxt;
    end
  end

  // Next-state: abort beats start beats pause_toggle
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_prescaler_nxt = r_prescaler;
    w_sec_tick_nxt  = 1'b0;

    if (abort) begin
      w_state_nxt     = S_IDLE;
      w_remaining_nxt = '0;
      w_prescaler_nxt = '0;
    end else if (start) begin
      w_remaining_nxt = max_time;
      w_prescaler_nxt = '0;
      w_state_nxt     = (max_time != '0) ? S_RUNNING : S_EXPIRED;
    end else begin
      case (r_state)
        S_RUNNING: begin
          if (r_prescaler == PRE_LAST) begin
            // Wrap: the decrement always lands, even if a pause arrives this cycle
            w_prescaler_nxt = '0;
            w_remaining_nxt = r_remaining - REM_W'(1);
            w_sec_tick_nxt  = 1'b1;
            if (r_remaining <= REM_W'(1)) begin
              w_remaining_nxt = '0;
              w_state_nxt     = S_EXPIRED;
            end
          end else begin
            w_prescaler_nxt = r_prescaler + PRE_W'(1);
          end
          if (pause_toggle && (w_state_nxt == S_RUNNING)) begin
            w_state_nxt = S_PAUSED;
          end
        end
        S_PAUSED: begin
          if (pause_toggle) begin
            w_state_nxt = S_RUNNING;
          end
        end
        S_IDLE:    w_state_nxt = S_IDLE;
        S_EXPIRED: w_state_nxt = S_EXPIRED;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Status decode straight from the state register
  assign running   = (r_state == S_RUNNING);
  assign paused    = (r_state == S_PAUSED);
  assign game_over = (r_state == S_EXPIRED);
  assign sec_tick  = r_sec_tick;
  assign warn      = (running || paused) && (r_remaining != '0) && (r_remaining <= WARN_LIM);

  // IDLE previews the configured length; other states show the live count
  assign w_disp     = (r_state == S_IDLE) ? max_time : r_remaining;
  assign w_disp_sec = SEC_W'(w_disp % REM_W'(60));
  assign A          = 4'(w_disp / REM_W'(60));
  assign B          = 4'(w_disp_sec / SEC_W'(10));
  assign C          = 4'(w_disp_sec % SEC_W'(10));

endmodule
